// File: rtl/bus_arbiter_if.sv
// Shared memory bus arbiter interface: two requesting masters (M0, M1) and
// the single slave bus they share.
// Modport "master" is the arbiter's view: it takes requests and slave read
// data, and drives grants, acks, returned read data and the slave bus.
// Modport "slave" is the opposite side: the requesters together with the
// memory/IO bus mux.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              m0Req;
  logic [ADDR_W-1:0] m0Address;
  logic [31:0]       m0DataOut;
  logic              m0WriteEnable;
  logic              m0Grant;
  logic              m0Ack;
  logic [31:0]       m0DataIn;

  logic              m1Req;
  logic [ADDR_W-1:0] m1Address;
  logic [31:0]       m1DataOut;
  logic              m1WriteEnable;
  logic              m1Grant;
  logic              m1Ack;
  logic [31:0]       m1DataIn;

  logic [ADDR_W-1:0] address;
  logic [31:0]       dataOut;
  logic              busWriteEnable;
  logic [31:0]       dataIn;

  modport master (
    input  m0Req, m0Address, m0DataOut, m0WriteEnable,
    output m0Grant, m0Ack, m0DataIn,
    input  m1Req, m1Address, m1DataOut, m1WriteEnable,
    output m1Grant, m1Ack, m1DataIn,
    output address, dataOut, busWriteEnable,
    input  dataIn
  );

  modport slave (
    output m0Req, m0Address, m0DataOut, m0WriteEnable,
    input  m0Grant, m0Ack, m0DataIn,
    output m1Req, m1Address, m1DataOut, m1WriteEnable,
    input  m1Grant, m1Ack, m1DataIn,
    input  address, dataOut, busWriteEnable,
    output dataIn
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, one-slave arbiter for the shared 32-bit memory bus.
// M0 (fetch/load-store) and M1 (debug loader / DMA) compete for the slave.
// One master is granted per transaction; the slave bus is driven from
// registers, the arbiter waits LATENCY cycles, captures read data and
// returns a one-cycle ack to the winner.
// Optional feature: define BUS_ARBITER_ROUND_ROBIN_EN to make simultaneous
// requests alternate between masters. Without it M0 always wins ties.
module bus_arbiter #(
  parameter int LATENCY = 2,   // 1..15 cycles from address valid to dataIn valid
  parameter int ADDR_W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.master bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t     state;
  logic [3:0] count;
  logic       winner;      // 0 = M0 owns the current transaction, 1 = M1
  logic       lastWinner;  // owner of the most recently completed transaction
  logic       tieToM1;     // on a simultaneous request, give the bus to M1
  logic       pick;        // master chosen this cycle when in IDLE

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  // Alternate on contention: whoever did not win last time goes next.
  assign tieToM1 = ~lastWinner;
`else
  // Fixed priority; lastWinner is still maintained but masked out here.
  assign tieToM1 = lastWinner & 1'b0;
`endif

  // Winner selection: a lone requester always wins, ties use tieToM1.
  always_comb begin
    pick = 1'b0;
    if (bus.m0Req && bus.m1Req) begin
      pick = tieToM1;
    end else begin
      pick = bus.m1Req;
    end
  end

  // Arbitration FSM with all bus-facing outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      count              <= 4'd0;
      winner             <= 1'b0;
      lastWinner         <= 1'b1;
      bus.m0Grant        <= 1'b0;
      bus.m1Grant        <= 1'b0;
      bus.m0Ack          <= 1'b0;
      bus.m1Ack          <= 1'b0;
      bus.m0DataIn       <= 32'd0;
      bus.m1DataIn       <= 32'd0;
      bus.address        <= '0;
      bus.dataOut        <= 32'd0;
      bus.busWriteEnable <= 1'b0;
    end else begin
      // Acks are single-cycle pulses.
      bus.m0Ack <= 1'b0;
      bus.m1Ack <= 1'b0;
      case (state)
        IDLE: begin
          // address/dataOut keep their last values while the bus is idle.
          bus.busWriteEnable <= 1'b0;
          if (bus.m0Req || bus.m1Req) begin
            winner <= pick;
            if (pick) begin
              bus.address        <= bus.m1Address;
              bus.dataOut        <= bus.m1DataOut;
              bus.busWriteEnable <= bus.m1WriteEnable;
              bus.m1Grant        <= 1'b1;
            end else begin
              bus.address        <= bus.m0Address;
              bus.dataOut        <= bus.m0DataOut;
              bus.busWriteEnable <= bus.m0WriteEnable;
              bus.m0Grant        <= 1'b1;
            end
            count <= 4'(LATENCY);
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (count > 4'd1) begin
            count <= count - 4'd1;
          end else begin
            // Completion edge: dataIn is valid now for a read.
            if (!bus.busWriteEnable) begin
              if (winner) begin
                bus.m1DataIn <= bus.dataIn;
              end else begin
                bus.m0DataIn <= bus.dataIn;
              end
            end
            if (winner) begin
              bus.m1Ack   <= 1'b1;
              bus.m1Grant <= 1'b0;
            end else begin
              bus.m0Ack   <= 1'b1;
              bus.m0Grant <= 1'b0;
            end
            bus.busWriteEnable <= 1'b0;
            lastWinner         <= winner;
            count              <= 4'd0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the shared 32-bit memory bus.
- M0 is the instruction decoder's fetch/load-store port. M1 is a secondary requester: debug loader or DMA.
- Grants one master per transaction, drives the slave bus with registered outputs, waits a fixed slave latency, and returns read data with a one-cycle ack pulse.
- Placed between the CPU core and the RAM/ROM/IO bus mux.

Parameters:
- LATENCY, 2, cycles from bus address valid to slave dataIn valid (legal range 1..15).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0Req  in  1  M0 request; hold high until m0Ack.
- m0Address  in  ADDR_W  M0 address.
- m0DataOut  in  32  M0 write data.
- m0WriteEnable  in  1  1 => write, 0 => read.
- m0Grant  out  1  M0 owns bus.
- m0Ack  out  1  one-cycle completion pulse.
- m0DataIn  out  32  M0 read data.
- m1Req, m1Address, m1DataOut, m1WriteEnable, m1Grant, m1Ack, m1DataIn: same as M0, for M1.
- address  out  ADDR_W  slave bus address.
- dataOut  out  32  slave write data.
- busWriteEnable  out  1  1 => WRITE, 0 => READ.
- dataIn  in  32  slave read data.

Behaviour:
- Reset (async, takes effect immediately, including mid-transaction):
  - FSM to IDLE, counter 0, lastWinner = 1.
  - All outputs 0: grants, acks, mXDataIn, address, dataOut, busWriteEnable.
  - An aborted transaction never acks.
- FSM states: IDLE, ACCESS.
- IDLE:
  - No req: stay. address and dataOut hold their last values; busWriteEnable = 0.
  - Any req:
    - Choose winner W (fixed priority: M0 wins ties).
    - Latch mW address, data and writeEnable onto address/dataOut/busWriteEnable.
    - mWGrant <= 1, counter <= LATENCY, go to ACCESS.
- ACCESS:
  - Each edge with counter > 1: counter decrements.
  - Edge with counter == 1 (completion):
    - For a read, mWDataIn <= dataIn.
    - mWAck <= 1 for exactly one cycle.
    - mWGrant <= 0, busWriteEnable <= 0, lastWinner <= W, go to IDLE.
- Timing, with the request sampled at edge E0:
  - Bus valid and grant high from E0.
  - dataIn sampled at E0+LATENCY.
  - Ack high during the cycle after E0+LATENCY.
  - Back-to-back throughput: one transaction per LATENCY+1 cycles.
- Write transactions leave mXDataIn unchanged.
- mXDataIn holds until the next read completion for that master.
- Master inputs are sampled only at the grant edge. Changes to address, data or writeEnable during ACCESS are ignored.
- Dropping req during ACCESS does not abort; the transaction completes and acks.
- Req still high in the IDLE cycle after ack (ack visible) is a new request. Masters drop req on the edge where they see ack.
- Grants are mutually exclusive. At most one ack is asserted per cycle.
- The grant of a master never overlaps that master's ack cycle.

Optional Feature:
- Macro: BUS_ARBITER_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, the master != lastWinner wins, so alternation is guaranteed under sustained contention. A single requester always wins.
- Undefined: fixed priority, M0 always wins ties; lastWinner is still tracked but unused.

Test Plan:
- LATENCY=2, M0 read of 0x00000010, slave returns 0xDEADBEEF two cycles after address:
  - address=0x10 and m0Grant high from the edge after the request.
  - m0Ack pulses 3 cycles after the request is sampled.
  - m0DataIn=0xDEADBEEF.
- M1 write, address 0x20, data 0x12345678:
  - busWriteEnable=1 and dataOut=0x12345678 for 2 cycles.
  - m1Ack pulses; m1DataIn unchanged; busWriteEnable=0 after completion.
- M0 and M1 request in the same cycle, both held for 4 transactions:
  - Without macro: grants go M0,M0,M0,M0 (M1 starves).
  - With macro: grants go M0,M1,M0,M1.
- Assert reset 1 cycle into ACCESS: all outputs 0 immediately, no ack issued, and a new M1 request after reset is granted normally.
- M0 changes m0Address from 0x40 to 0x80 during ACCESS: address stays 0x40 until completion.
- LATENCY=1, back-to-back M0 reads with req held high: ack every 2 cycles, and grant never overlaps the ack cycle.
